// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller.
//   scan_state_t : scan FSM states (IDLE, SHOW, GAP)
//   SEG_OFF      : segment pattern with every segment dark
//   BCD_W        : width of one BCD digit
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b0;
  localparam int BCD_W = 4;

endpackage

// File: rtl/scan_timer.sv
// Dwell/gap down-counter. start loads length (duration minus one); done is
// high in the final cycle of the interval. The counter parks at zero.
//   clk, reset : clock and synchronous active-high reset
//   start      : load a new interval
//   length     : interval length minus one
//   done       : terminal count reached
module scan_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] length,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (start) begin
      count_reg <= length;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/seg7.sv
// Seven-segment decoder, segment order {g,f,e,d,c,b,a}, active high.
// Codes 10..15 show A, b, C, d, E, F.
//   code     : 4-bit digit code
//   segments : decoded segment pattern
module seg7
  import seg_pkg::*;
(
  input  logic [BCD_W-1:0] code,
  output logic [6:0]       segments
);

  always_comb begin
    segments = SEG_OFF;
    case (code)
      4'h0: segments = 7'h3F;
      4'h1: segments = 7'h06;
      4'h2: segments = 7'h5B;
      4'h3: segments = 7'h4F;
      4'h4: segments = 7'h66;
      4'h5: segments = 7'h6D;
      4'h6: segments = 7'h7D;
      4'h7: segments = 7'h07;
      4'h8: segments = 7'h7F;
      4'h9: segments = 7'h6F;
      4'hA: segments = 7'h77;
      4'hB: segments = 7'h7C;
      4'hC: segments = 7'h39;
      4'hD: segments = 7'h5E;
      4'hE: segments = 7'h79;
      4'hF: segments = 7'h71;
      default: segments = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scans NUM_DIGITS common-cathode digits through one shared seg7 decoder.
// A pending buffer accepts new values at any time; it is copied into the
// displayed (shadow) buffer only at a frame wrap or while idle, so a frame
// never mixes old and new digits.
//   clk, reset  : clock and synchronous active-high reset
//   enable      : scan enable, 0 keeps the display dark
//   lz_blank    : leading-zero blanking enable
//   load_valid  : new BCD value offered on load_data
//   load_data   : BCD value, digit 0 in the low nibble
//   load_ready  : pending buffer empty
//   segments    : segment drive, dark when no digit is selected
//   digit_sel   : one-hot digit enable
//   frame_done  : one-cycle pulse in the first cycle of each frame
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 4,
  parameter int BLANK      = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        lz_blank,
  input  logic                        load_valid,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_data,
  output logic                        load_ready,
  output logic [6:0]                  segments,
  output logic [NUM_DIGITS-1:0]       digit_sel,
  output logic                        frame_done
);

  localparam int MAX_LEN = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] DWELL_LEN = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LEN = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

  scan_state_t state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] shadow_reg, shadow_next, pending_reg;
  logic pend_valid_reg;
  logic load_ready_reg;
  logic [NUM_DIGITS-1:0] digit_sel_reg, sel_next;
  logic [BCD_W-1:0] digit_code_reg, code_next;
  logic frame_done_reg, frame_start;
  logic timer_start, timer_done, advance, wrap, commit;
  logic [CW-1:0] timer_len;
  logic [NUM_DIGITS-1:0] blanked;
  logic [6:0] seg_raw;

  scan_timer #(.W(CW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (timer_start),
    .length (timer_len),
    .done   (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      shadow_reg     <= '0;
      pending_reg    <= '0;
      pend_valid_reg <= 1'b0;
      load_ready_reg <= 1'b1;
      digit_sel_reg  <= '0;
      digit_code_reg <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      shadow_reg     <= shadow_next;
      digit_sel_reg  <= sel_next;
      digit_code_reg <= code_next;
      frame_done_reg <= frame_start;
      if (load_valid && load_ready_reg) begin
        pending_reg    <= load_data;
        pend_valid_reg <= 1'b1;
        load_ready_reg <= 1'b0;
      end else begin
        if (commit) pend_valid_reg <= 1'b0;
        // Lags the pending flag by one cycle so ready reappears the cycle
        // after the commit edge.
        load_ready_reg <= !pend_valid_reg;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    timer_start = 1'b0;
    timer_len   = DWELL_LEN;
    frame_start = 1'b0;
    wrap        = 1'b0;
    advance     = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      idx_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next  = SHOW;
          idx_next    = '0;
          timer_start = 1'b1;
          frame_start = 1'b1;
        end
        SHOW: begin
          if (timer_done) begin
            if (BLANK > 0) begin
              state_next  = GAP;
              timer_start = 1'b1;
              timer_len   = BLANK_LEN;
            end else begin
              advance = 1'b1;
            end
          end
        end
        GAP: begin
          if (timer_done) advance = 1'b1;
        end
        default: begin
          state_next = IDLE;
          idx_next   = '0;
        end
      endcase
      if (advance) begin
        state_next  = SHOW;
        timer_start = 1'b1;
        timer_len   = DWELL_LEN;
        if (idx_reg == LAST_IDX) begin
          idx_next    = '0;
          wrap        = 1'b1;
          frame_start = 1'b1;
        end else begin
          idx_next = idx_reg + IW'(1);
        end
      end
    end
  end

  assign commit      = pend_valid_reg && (wrap || state_reg == IDLE);
  assign shadow_next = commit ? pending_reg : shadow_reg;

  // Digit i is blanked when it and every more significant digit are zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_first
        assign blanked[gi] = 1'b0;
      end else begin : g_upper
        assign blanked[gi] = lz_blank && (shadow_next[NUM_DIGITS-1:gi] == '0);
      end
    end
  endgenerate

  // Outputs are computed from next-state values so the registered copies
  // line up with the state they describe.
  always_comb begin
    sel_next  = '0;
    code_next = shadow_next[idx_next];
    if (state_next == SHOW && !blanked[idx_next]) sel_next[idx_next] = 1'b1;
  end

  seg7 u_seg7 (
    .code     (digit_code_reg),
    .segments (seg_raw)
  );

  assign segments   = (|digit_sel_reg) ? seg_raw : SEG_OFF;
  assign digit_sel  = digit_sel_reg;
  assign frame_done = frame_done_reg;
  assign load_ready = load_ready_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, dwell 4, gap 1).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset, enable, lz_blank, load_valid;
  logic [15:0] load_data;
  logic        load_ready, frame_done;
  logic [6:0]  segments;
  logic [3:0]  digit_sel;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic            lz;
    logic [15:0]     value;
    logic [3:0]      sel;
    logic [3:0][6:0] seg;
  } vec_t;

  vec_t vecs[7];
  vec_t exp_q[$];

  seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL(4), .BLANK(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .lz_blank   (lz_blank),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .segments   (segments),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [3:0] c);
    case (c)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    while (frame_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (frame_done !== 1'b1) chk("frame_timeout", 32'(frame_done), 32'd1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (load_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (load_ready !== 1'b1) chk("ready_timeout", 32'(load_ready), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] v);
    wait_ready();
    load_data  = v;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  // Starts at a frame_done cycle; samples the first cycle of each slot.
  task automatic capture(output logic [3:0] sel_seen, output logic [3:0][6:0] seg_seen);
    sel_seen = '0;
    seg_seen = '0;
    for (int k = 0; k < 20; k++) begin
      if (k % 5 == 0) begin
        sel_seen[k/5] = digit_sel[k/5];
        seg_seen[k/5] = segments;
      end
      tick();
    end
  endtask

  initial begin
    logic [3:0]      sel_seen;
    logic [3:0][6:0] seg_seen;
    logic [3:0]      e_sel;
    vec_t            e;

    vecs[0] = '{lz: 1'b0, value: 16'h1234, sel: 4'hF, seg: {7'h06, 7'h5B, 7'h4F, 7'h66}};
    vecs[1] = '{lz: 1'b1, value: 16'h0050, sel: 4'h3, seg: {7'h00, 7'h00, 7'h6D, 7'h3F}};
    vecs[2] = '{lz: 1'b1, value: 16'h0000, sel: 4'h1, seg: {7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[3] = '{lz: 1'b0, value: 16'h0000, sel: 4'hF, seg: {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    vecs[4] = '{lz: 1'b1, value: 16'h9080, sel: 4'hF, seg: {7'h6F, 7'h3F, 7'h7F, 7'h3F}};
    vecs[5] = '{lz: 1'b1, value: 16'h00AF, sel: 4'h3, seg: {7'h00, 7'h00, 7'h77, 7'h71}};
    vecs[6] = '{lz: 1'b1, value: 16'h0001, sel: 4'h1, seg: {7'h00, 7'h00, 7'h00, 7'h06}};

    reset = 1'b1; enable = 1'b0; lz_blank = 1'b0; load_valid = 1'b0; load_data = '0;
    tick(2);
    chk("reset_sel", 32'(digit_sel), 32'h0);
    chk("reset_seg", 32'(segments), 32'h0);
    chk("reset_fd", 32'(frame_done), 32'h0);
    chk("reset_ready", 32'(load_ready), 32'h1);

    reset = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    // Scan timing from shadow = 0: {digit_sel, frame_done, segments}.
    for (int k = 0; k < 41; k++) begin
      e_sel = (k % 5 < 4) ? (4'b0001 << ((k % 20) / 5)) : 4'b0000;
      chk($sformatf("scan_k%0d", k), {20'h0, digit_sel, frame_done, segments},
          {20'h0, e_sel, (k % 20 == 0), (e_sel != 0) ? 7'h3F : 7'h00});
      tick();
    end

    // Mid-frame load during digit 2, then a refused retry with 9999.
    do_load(16'h5678);
    wait_ready();
    wait_frame();
    tick(10);
    load_data = 16'h1234; load_valid = 1'b1;
    tick();
    chk("midload_ready_low", 32'(load_ready), 32'h0);
    load_data = 16'h9999;
    tick();
    chk("old_d2_sel", 32'(digit_sel), 32'h4);
    chk("old_d2_seg", 32'(segments), 32'(seg_ref(4'h6)));
    tick(4);
    chk("old_d3_seg", 32'(segments), 32'(seg_ref(4'h5)));
    tick(4);
    chk("wrap_fd", 32'(frame_done), 32'h1);
    chk("wrap_sel", 32'(digit_sel), 32'h1);
    chk("wrap_seg_new", 32'(segments), 32'(seg_ref(4'h4)));
    chk("wrap_ready_low", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    tick();
    chk("ready_after_commit", 32'(load_ready), 32'h1);
    tick(14);
    chk("kept_first_d3", 32'(segments), 32'(seg_ref(4'h1)));

    // Table vectors through the scoreboard.
    for (int v = 0; v < 7; v++) begin
      lz_blank = vecs[v].lz;
      do_load(vecs[v].value);
      exp_q.push_back(vecs[v]);
      wait_ready();
      wait_frame();
      capture(sel_seen, seg_seen);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_sel", v), 32'(sel_seen), 32'(e.sel));
      for (int d = 0; d < 4; d++)
        chk($sformatf("vec%0d_seg%0d", v, d), 32'(seg_seen[d]), 32'(e.seg[d]));
    end

    // Enable dropped in the gap after digit 1.
    lz_blank = 1'b0;
    wait_frame();
    tick(9);
    chk("gap_sel", 32'(digit_sel), 32'h0);
    enable = 1'b0;
    tick();
    chk("dis_sel", 32'(digit_sel), 32'h0);
    chk("dis_seg", 32'(segments), 32'h0);
    chk("dis_fd", 32'(frame_done), 32'h0);
    tick(3);
    chk("dis_hold", 32'({digit_sel, frame_done}), 32'h0);
    enable = 1'b1;
    tick();
    chk("reen_fd", 32'(frame_done), 32'h1);
    chk("reen_sel", 32'(digit_sel), 32'h1);

    // Reset mid-SHOW with a pending load.
    tick();
    load_data = 16'h8888; load_valid = 1'b1;
    tick();
    chk("rst_pend_ready_low", 32'(load_ready), 32'h0);
    load_valid = 1'b0; reset = 1'b1;
    tick();
    chk("rst_sel", 32'(digit_sel), 32'h0);
    chk("rst_seg", 32'(segments), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h1);
    reset = 1'b0;
    tick();
    chk("rst_restart_fd", 32'(frame_done), 32'h1);
    chk("rst_d0_seg", 32'(segments), 32'h3F);
    tick(15);
    chk("rst_d3_sel", 32'(digit_sel), 32'h8);
    chk("rst_d3_seg", 32'(segments), 32'h3F);
    tick(20);
    chk("rst_nopend_d3", 32'(segments), 32'h3F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
